seq_det_ctrl: RTL and testbench

Programmable controller for bit-serial Mealy sequence detection. It holds a run-time configuration (pattern, length, overlap mode, match limit) and accepts a serial bit stream through a valid/ready handshake. It flags each match in the same cycle as the completing bit, counts matches, and ends a run on limit, abort or (optionally) input timeout. It sits between a serial bit source and the status/interrupt logic that consumes detection counts.

---
 rtl/seq_det_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-time programmable bit-serial Mealy sequence detector.
// Holds pattern/length/overlap/limit configuration, accepts bits through a
// valid/ready handshake, flags matches combinationally and counts them.
// Optional feature macro: SEQ_DET_CTRL_TIMEOUT_EN (input idle timeout).
module seq_det_ctrl #(
    parameter int               PAT_W   = 4,
    parameter int               LEN_W   = 3,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1010,
    parameter int               TO_CYC  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic             cfg_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(4);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W:0]   LEN_MAX  = (LEN_W+1)'(PAT_W);

    // Parameter sanity: cfg_len must be able to express PAT_W, timeout nonzero.
    if ((1 << LEN_W) <= PAT_W || PAT_W < 2 || TO_CYC < 1) begin : g_param_chk
        $error("seq_det_ctrl: illegal parameter combination");
    end

    logic [1:0]       state;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic             ovl;
    logic [CNT_W-1:0] limit;
    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic [LEN_W:0]   fill_inc;
    logic [CNT_W:0]   cnt_inc;
    logic             len_ok;
    logic             cfg_ok;
    logic             accept;
    logic             match;
    logic             limit_hit;
    logic             to_hit;

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign din_ready = (state == ST_RUN) && !abort;
    assign accept    = din_valid && din_ready;
    assign window    = {hist, din};
    assign fill_inc  = {1'b0, fill} + 1'b1;
    assign cnt_inc   = {1'b0, match_cnt} + 1'b1;
    assign len_ok    = (cfg_len != '0) && ({1'b0, cfg_len} <= LEN_MAX);
    assign cfg_ok    = cfg_we && (state == ST_IDLE) && len_ok;

    // Compare mask selecting the low len bits of window and pattern.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len));
        end
    end

    // Match decode: enough history collected and masked window equals pattern.
    always_comb begin
        match     = (fill_inc >= {1'b0, len}) && (((window ^ pat) & mask) == '0);
        limit_hit = match && (limit != '0) && (cnt_inc == {1'b0, limit});
    end

    assign detect = accept && match;

    // Configuration registers and reject pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat     <= PAT_RST;
            len     <= LEN_RST;
            ovl     <= 1'b0;
            limit   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                pat   <= cfg_pattern;
                len   <= cfg_len;
                ovl   <= cfg_overlap;
                limit <= cfg_limit;
            end
        end
    end

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    // The counter only ever reaches TO_CYC-1; the idle cycle that would take it
    // to TO_CYC is the one that schedules DONE.
    assign to_hit = (to_cnt == TO_W'(TO_CYC - 1));

    // Idle-cycle counter and timeout status flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                to_cnt    <= '0;
                timed_out <= 1'b0;
            end
        end else if (state == ST_RUN && !abort) begin
            if (accept) begin
                to_cnt <= '0;
            end else if (to_hit) begin
                timed_out <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign to_hit    = 1'b0;
    assign timed_out = 1'b0;
`endif

    // Run control, history shift register, fill count and match counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hist      <= '0;
                        fill      <= '0;
                        match_cnt <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        if (match && !ovl) begin
                            hist <= '0;
                            fill <= '0;
                        end else begin
                            hist <= window[PAT_W-2:0];
                            if (fill != FILL_MAX) begin
                                fill <= fill_inc[LEN_W-1:0];
                            end
                        end
                        if (match && match_cnt != '1) begin
                            match_cnt <= cnt_inc[CNT_W-1:0];
                        end
                        if (limit_hit) begin
                            state <= ST_DONE;
                        end
                    end else if (to_hit) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed scoreboard bench for seq_det_ctrl.
// Expected detect values are queued per driven bit; a monitor pops one entry
// for every accepted bit and compares it with the DUT's detect output.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_pattern = '0;
    logic [2:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_limit = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       detect;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;
    logic       timed_out;
    logic       cfg_err;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic exp_q[$];

    seq_det_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_limit   (cfg_limit),
        .start       (start),
        .abort       (abort),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .detect      (detect),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one expected detect per accepted bit.
    always @(negedge clk) begin
        if (reset && din_valid && din_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow: accepted bit with no expectation at %0t", $time);
            end else begin
                chk("detect", {31'd0, detect}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    // Count done pulses for the never/exactly-once checks.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // bits[i] is the i-th bit sent; exp[i] the detect expected for it.
    task automatic send(input logic [7:0] bits, input logic [7:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            din       = bits[i];
            din_valid = 1'b1;
            exp_q.push_back(exp[i]);
        end
        step();
        din_valid = 1'b0;
    endtask

    task automatic start_run;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_abort;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic write_cfg(input logic [3:0] p, input logic [2:0] l, input logic o, input logic [7:0] lim);
        step();
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_limit   = lim;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        int d0;
        // Reset state
        #3;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ready", {31'd0, din_ready}, 0);
        chk("rst_cnt", {24'd0, match_cnt}, 0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 0);
        chk("rst_timed_out", {31'd0, timed_out}, 0);
        chk("rst_detect", {31'd0, detect}, 0);
        step();
        reset = 1'b1;

        // Non-overlapping with defaults 1010/len4
        start_run();
        @(negedge clk);
        chk("t1_busy_after_start", {31'd0, busy}, 1);
        chk("t1_ready_after_start", {31'd0, din_ready}, 1);
        send(8'b01010101, 8'b10001000, 8);
        @(negedge clk);
        chk("t1_cnt", {24'd0, match_cnt}, 2);
        chk("t1_no_done", done_cnt, 0);
        chk("t1_still_busy", {31'd0, busy}, 1);
        do_abort();

        // Overlapping 1010/len4
        write_cfg(4'b1010, 3'd4, 1'b1, 8'd0);
        start_run();
        send(8'b00010101, 8'b00101000, 6);
        @(negedge clk);
        chk("t2_cnt", {24'd0, match_cnt}, 2);
        do_abort();

        // Limit end: 011/len3/limit2, config written together with start
        step();
        cfg_we = 1'b1; cfg_pattern = 4'b0011; cfg_len = 3'd3; cfg_overlap = 1'b0; cfg_limit = 8'd2;
        start = 1'b1;
        step();
        cfg_we = 1'b0; start = 1'b0;
        send(8'b00110110, 8'b00100100, 6);
        @(negedge clk);
        chk("t3_done", {31'd0, done}, 1);
        chk("t3_done_busy", {31'd0, busy}, 0);
        chk("t3_done_ready", {31'd0, din_ready}, 0);
        chk("t3_cnt", {24'd0, match_cnt}, 2);
        step();
        @(negedge clk);
        chk("t3_done_gone", {31'd0, done}, 0);
        chk("t3_idle_busy", {31'd0, busy}, 0);
        chk("t3_idle_ready", {31'd0, din_ready}, 0);
        chk("t3_done_once", done_cnt, 1);
        chk("t3_cnt_hold", {24'd0, match_cnt}, 2);

        // Rejected configuration: write during RUN, then len=0 in IDLE
        start_run();
        write_cfg(4'b1111, 3'd4, 1'b1, 8'd0);
        @(negedge clk);
        chk("t4_err_run", {31'd0, cfg_err}, 1);
        @(negedge clk);
        chk("t4_err_run_clear", {31'd0, cfg_err}, 0);
        do_abort();
        write_cfg(4'b1111, 3'd0, 1'b1, 8'd0);
        @(negedge clk);
        chk("t4_err_len0", {31'd0, cfg_err}, 1);
        @(negedge clk);
        chk("t4_err_len0_clear", {31'd0, cfg_err}, 0);
        // Old config (011/len3/non-overlap/limit2) must still be in force
        start_run();
        send(8'b00110111, 8'b00100000, 6);
        @(negedge clk);
        chk("t4_cnt", {24'd0, match_cnt}, 1);
        chk("t4_busy", {31'd0, busy}, 1);
        do_abort();

        // Abort together with the completing bit
        write_cfg(4'b1010, 3'd4, 1'b0, 8'd0);
        start_run();
        send(8'b00000101, 8'b00000000, 3);
        d0 = done_cnt;
        step();
        din = 1'b0; din_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("t5_abort_detect", {31'd0, detect}, 0);
        chk("t5_abort_ready", {31'd0, din_ready}, 0);
        step();
        din_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("t5_abort_idle", {31'd0, busy}, 0);
        chk("t5_abort_no_done", done_cnt, d0);
        chk("t5_abort_cnt", {24'd0, match_cnt}, 0);

        // Asynchronous reset mid-run
        start_run();
        send(8'b00000101, 8'b00001000, 4);
        @(negedge clk);
        chk("t6_cnt_before", {24'd0, match_cnt}, 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_cnt", {24'd0, match_cnt}, 0);
        chk("t6_rst_ready", {31'd0, din_ready}, 0);
        step();
        reset = 1'b1;

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        // Timeout after 16 idle cycles
        start_run();
        send(8'b00000001, 8'b00000000, 2);
        repeat (15) step();
        @(negedge clk);
        chk("t7_busy_pre", {31'd0, busy}, 1);
        chk("t7_done_pre", {31'd0, done}, 0);
        step();
        @(negedge clk);
        chk("t7_done", {31'd0, done}, 1);
        chk("t7_timed_out", {31'd0, timed_out}, 1);
        chk("t7_cnt", {24'd0, match_cnt}, 0);
`else
        // Without the timeout feature a stalled run stays busy
        start_run();
        send(8'b00000001, 8'b00000000, 2);
        repeat (20) step();
        @(negedge clk);
        chk("t7_busy_stall", {31'd0, busy}, 1);
        chk("t7_timed_out", {31'd0, timed_out}, 0);
        do_abort();
`endif

        step();
        step();
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
